// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - retire-time store write buffer with in-order D-cache drain and load forwarding
// Optional store coalescing into the youngest entry is enabled by defining STORE_WB_COALESCE_EN.
module store_write_buffer #(
    parameter int WB_SZ           = 4,
    parameter int WB_DRAIN_THRESH = 2,
    parameter int WB_AGE_LIMIT    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        store_req_valid,
    input  logic [31:0] store_req_addr,
    input  logic [31:0] store_req_data,
    input  logic [3:0]  store_req_byte_mask,
    output logic        store_req_accepted,
    output logic        dc_wr_valid,
    output logic [31:0] dc_wr_addr,
    output logic [63:0] dc_wr_data,
    output logic [7:0]  dc_wr_byte_mask,
    input  logic        dc_wr_accepted,
    input  logic        drain_all,
    input  logic [31:0] load_req_addr,
    output logic [31:0] wb_load_data,
    output logic [3:0]  wb_data_mask,
    output logic        wb_empty
);

    localparam int IDX_W = $clog2(WB_SZ);
    localparam int PTR_W = IDX_W + 1;
    localparam int AGE_W = $clog2(WB_AGE_LIMIT + 1);

    localparam logic [PTR_W-1:0] SZ_C     = PTR_W'(WB_SZ);
    localparam logic [PTR_W-1:0] THRESH_C = PTR_W'(WB_DRAIN_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [AGE_W-1:0] AGE_C    = AGE_W'(WB_AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    logic [28:0] ent_blk  [WB_SZ];
    logic [63:0] ent_data [WB_SZ];
    logic [7:0]  ent_mask [WB_SZ];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [AGE_W-1:0] age;
    state_t           state;
    state_t           state_next;

    logic [63:0] st_data;
    logic [7:0]  st_mask;
    logic        coalesce_hit;
    logic        alloc;
    logic        pop;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{store_req_addr[1:0], load_req_addr[1:0]};

    // Pointers carry one extra wrap bit, so their difference is the occupancy 0..WB_SZ.
    assign count    = tail - head;
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign wb_empty = (count == '0);

    assign st_data = store_req_addr[2] ? {store_req_data, 32'h0} : {32'h0, store_req_data};
    assign st_mask = store_req_addr[2] ? {store_req_byte_mask, 4'h0} : {4'h0, store_req_byte_mask};

`ifdef STORE_WB_COALESCE_EN
    logic [IDX_W-1:0] young_idx;
    logic             merge;

    // The head must not change while the D-cache is looking at it.
    assign young_idx    = tail_idx - IDX_W'(1);
    assign coalesce_hit = (count != '0)
                          && (ent_blk[young_idx] == store_req_addr[31:3])
                          && !((state == S_PRESENT) && (young_idx == head_idx));
    assign merge        = store_req_accepted && coalesce_hit;
`else
    assign coalesce_hit = 1'b0;
`endif

    // A store offered during reset would be wiped, so it is never acknowledged.
    assign store_req_accepted = store_req_valid && !reset && ((count < SZ_C) || coalesce_hit);
    assign alloc              = store_req_accepted && !coalesce_hit;
    assign pop                = (state == S_PRESENT) && dc_wr_accepted;

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (alloc) begin
            ent_blk[tail_idx]  <= store_req_addr[31:3];
            ent_data[tail_idx] <= st_data;
            ent_mask[tail_idx] <= st_mask;
        end
`ifdef STORE_WB_COALESCE_EN
        if (merge) begin
            for (int b = 0; b < 8; b++) begin
                if (st_mask[b]) begin
                    ent_data[young_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
            ent_mask[young_idx] <= ent_mask[young_idx] | st_mask;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            age <= '0;
        end else if ((count == '0) || pop) begin
            age <= '0;
        end else if ((state == S_IDLE) && (age != AGE_C)) begin
            age <= age + AGE_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if ((count != '0) && ((count >= THRESH_C) || (age == AGE_C) || drain_all)) begin
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (dc_wr_accepted) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dc_wr_valid     = 1'b0;
        dc_wr_addr      = '0;
        dc_wr_data      = '0;
        dc_wr_byte_mask = '0;
        if (state == S_PRESENT) begin
            dc_wr_valid     = 1'b1;
            dc_wr_addr      = {ent_blk[head_idx], 3'b000};
            dc_wr_data      = ent_data[head_idx];
            dc_wr_byte_mask = ent_mask[head_idx];
        end
    end

    logic [IDX_W-1:0] fwd_idx;
    logic [31:0]      fwd_half_data;
    logic [3:0]       fwd_half_mask;

    // Walk oldest to newest so younger bytes overwrite older ones lane by lane.
    always_comb begin
        wb_load_data  = '0;
        wb_data_mask  = '0;
        fwd_idx       = '0;
        fwd_half_data = '0;
        fwd_half_mask = '0;
        for (int k = 0; k < WB_SZ; k++) begin
            fwd_idx       = head_idx + IDX_W'(k);
            fwd_half_data = load_req_addr[2] ? ent_data[fwd_idx][63:32] : ent_data[fwd_idx][31:0];
            fwd_half_mask = load_req_addr[2] ? ent_mask[fwd_idx][7:4] : ent_mask[fwd_idx][3:0];
            if ((PTR_W'(k) < count) && (ent_blk[fwd_idx] == load_req_addr[31:3])) begin
                for (int i = 0; i < 4; i++) begin
                    if (fwd_half_mask[i]) begin
                        wb_load_data[8*i +: 8] = fwd_half_data[8*i +: 8];
                        wb_data_mask[i]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed bench with a queue-level reference model for store_write_buffer
module tb_store_write_buffer;

    localparam int WB_SZ           = 4;
    localparam int WB_DRAIN_THRESH = 2;
    localparam int WB_AGE_LIMIT    = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        store_req_valid;
    logic [31:0] store_req_addr;
    logic [31:0] store_req_data;
    logic [3:0]  store_req_byte_mask;
    logic        store_req_accepted;
    logic        dc_wr_valid;
    logic [31:0] dc_wr_addr;
    logic [63:0] dc_wr_data;
    logic [7:0]  dc_wr_byte_mask;
    logic        dc_wr_accepted;
    logic        drain_all;
    logic [31:0] load_req_addr;
    logic [31:0] wb_load_data;
    logic [3:0]  wb_data_mask;
    logic        wb_empty;

    always #5 clock = ~clock;

    store_write_buffer #(
        .WB_SZ(WB_SZ),
        .WB_DRAIN_THRESH(WB_DRAIN_THRESH),
        .WB_AGE_LIMIT(WB_AGE_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .store_req_valid(store_req_valid),
        .store_req_addr(store_req_addr),
        .store_req_data(store_req_data),
        .store_req_byte_mask(store_req_byte_mask),
        .store_req_accepted(store_req_accepted),
        .dc_wr_valid(dc_wr_valid),
        .dc_wr_addr(dc_wr_addr),
        .dc_wr_data(dc_wr_data),
        .dc_wr_byte_mask(dc_wr_byte_mask),
        .dc_wr_accepted(dc_wr_accepted),
        .drain_all(drain_all),
        .load_req_addr(load_req_addr),
        .wb_load_data(wb_load_data),
        .wb_data_mask(wb_data_mask),
        .wb_empty(wb_empty)
    );

    typedef struct packed {
        logic [28:0] blk;
        logic [63:0] data;
        logic [7:0]  mask;
    } ent_t;

    ent_t mq[$];
    ent_t wlog[$];
    bit   m_present = 1'b0;
    int   m_age = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a queue of blocks, a presenting flag and an age count.
    always @(negedge clock) begin : compare
        int          n;
        int          ln;
        int          nage;
        bit          npres;
        bit          pop;
        logic        hit;
        logic        acc;
        logic [31:0] fd;
        logic [3:0]  fm;
        ent_t        e;
        ent_t        se;

        n   = mq.size();
        hit = 1'b0;
`ifdef STORE_WB_COALESCE_EN
        if (n > 0 && mq[n-1].blk == store_req_addr[31:3] && !(m_present && n == 1)) hit = 1'b1;
`endif
        acc = store_req_valid && !reset && (n < WB_SZ || hit);
        chk("accepted", store_req_accepted, acc);
        chk("wb_empty", wb_empty, n == 0);
        chk("dc_wr_valid", dc_wr_valid, m_present);
        if (m_present) begin
            chk("dc_wr_addr", dc_wr_addr, {mq[0].blk, 3'b000});
            chk("dc_wr_data", dc_wr_data, mq[0].data);
            chk("dc_wr_byte_mask", dc_wr_byte_mask, mq[0].mask);
        end else begin
            chk("dc_wr_idle_bus", {dc_wr_addr, dc_wr_byte_mask}, 64'h0);
        end

        fd = '0;
        fm = '0;
        for (int i = 0; i < 4; i++) begin
            ln = (load_req_addr[2] ? 4 : 0) + i;
            for (int k = n - 1; k >= 0; k--) begin
                if (!fm[i] && mq[k].blk == load_req_addr[31:3] && mq[k].mask[ln]) begin
                    fm[i]        = 1'b1;
                    fd[8*i +: 8] = mq[k].data[8*ln +: 8];
                end
            end
        end
        chk("wb_load_data", wb_load_data, fd);
        chk("wb_data_mask", wb_data_mask, fm);

        if (dc_wr_valid && dc_wr_accepted && !reset) begin
            e.blk  = dc_wr_addr[31:3];
            e.data = dc_wr_data;
            e.mask = dc_wr_byte_mask;
            wlog.push_back(e);
        end

        if (reset) begin
            mq.delete();
            m_present = 1'b0;
            m_age     = 0;
        end else begin
            pop = m_present && dc_wr_accepted;
            if (n == 0 || pop) nage = 0;
            else if (!m_present && m_age < WB_AGE_LIMIT) nage = m_age + 1;
            else nage = m_age;
            if (m_present) npres = !dc_wr_accepted;
            else npres = (n > 0) && (n >= WB_DRAIN_THRESH || m_age == WB_AGE_LIMIT || drain_all);
            if (acc) begin
                se.blk  = store_req_addr[31:3];
                se.data = store_req_addr[2] ? {store_req_data, 32'h0} : {32'h0, store_req_data};
                se.mask = store_req_addr[2] ? {store_req_byte_mask, 4'h0} : {4'h0, store_req_byte_mask};
                if (hit) begin
                    e = mq[n-1];
                    for (int b = 0; b < 8; b++) begin
                        if (se.mask[b]) e.data[8*b +: 8] = se.data[8*b +: 8];
                    end
                    e.mask    = e.mask | se.mask;
                    mq[n-1]   = e;
                end else begin
                    mq.push_back(se);
                end
            end
            if (pop) void'(mq.pop_front());
            m_age     = nage;
            m_present = npres;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        n = 0;
        store_req_valid     = 1'b1;
        store_req_addr      = a;
        store_req_data      = d;
        store_req_byte_mask = m;
        #1;
        while (!store_req_accepted && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk("put_accept", store_req_accepted, 1'b1);
        tick();
        store_req_valid = 1'b0;
    endtask

    task automatic drain_until_empty(input string name);
        int n;
        n              = 0;
        drain_all      = 1'b1;
        dc_wr_accepted = 1'b1;
        while (!wb_empty && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, wb_empty, 1'b1);
        drain_all = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        reset               = 1'b1;
        store_req_valid     = 1'b0;
        store_req_addr      = '0;
        store_req_data      = '0;
        store_req_byte_mask = '0;
        dc_wr_accepted      = 1'b0;
        drain_all           = 1'b0;
        load_req_addr       = '0;
        tick();
        tick();
        chk("rst_wb_empty", wb_empty, 1'b1);
        chk("rst_dc_wr_valid", dc_wr_valid, 1'b0);
        chk("rst_dc_wr_data", dc_wr_data, 64'h0);
        chk("rst_fwd_mask", wb_data_mask, 4'h0);
        chk("rst_accepted", store_req_accepted, 1'b0);
        reset = 1'b0;
        tick();

        // Basic drain
        dc_wr_accepted = 1'b1;
        base = wlog.size();
        put(32'h100, 32'hAABBCCDD, 4'hF);
        put(32'h104, 32'h11223344, 4'hF);
        n = 0;
        while (!(wb_empty && !dc_wr_valid) && n < 80) begin
            tick();
            n++;
        end
`ifdef STORE_WB_COALESCE_EN
        chk("basic_writes", wlog.size() - base, 1);
        if (wlog.size() >= base + 1) begin
            chk("basic0_addr", {wlog[base].blk, 3'b000}, 32'h100);
            chk("basic0_data", wlog[base].data, 64'h11223344_AABBCCDD);
            chk("basic0_mask", wlog[base].mask, 8'hFF);
        end
`else
        chk("basic_writes", wlog.size() - base, 2);
        if (wlog.size() >= base + 2) begin
            chk("basic0_addr", {wlog[base].blk, 3'b000}, 32'h100);
            chk("basic0_data", wlog[base].data, 64'h00000000_AABBCCDD);
            chk("basic0_mask", wlog[base].mask, 8'h0F);
            chk("basic1_addr", {wlog[base+1].blk, 3'b000}, 32'h100);
            chk("basic1_data", wlog[base+1].data, 64'h11223344_00000000);
            chk("basic1_mask", wlog[base+1].mask, 8'hF0);
        end
`endif

        // Full backpressure
        dc_wr_accepted = 1'b0;
        put(32'h1000, 32'h01010101, 4'hF);
        put(32'h2000, 32'h02020202, 4'hF);
        put(32'h3000, 32'h03030303, 4'hF);
        put(32'h4000, 32'h04040404, 4'hF);
        store_req_valid     = 1'b1;
        store_req_addr      = 32'h5000;
        store_req_data      = 32'h05050505;
        store_req_byte_mask = 4'hF;
        #1;
        chk("full_reject", store_req_accepted, 1'b0);
        tick();
        dc_wr_accepted = 1'b1;
        #1;
        chk("full_reject_same_pop", store_req_accepted, 1'b0);
        tick();
        dc_wr_accepted = 1'b0;
        #1;
        chk("full_accept_after_pop", store_req_accepted, 1'b1);
        tick();
        store_req_valid = 1'b0;
        drain_until_empty("full");
        tick();

        // Age drain
        dc_wr_accepted = 1'b1;
        put(32'h300, 32'h12345678, 4'hF);
        n = 0;
        while (!dc_wr_valid && n < 40) begin
            tick();
            n++;
        end
        chk("age_latency", n, 17);
        chk("age_not_yet_empty", wb_empty, 1'b0);
        tick();
        chk("age_empty_after_handshake", wb_empty, 1'b1);

        // Forwarding
        dc_wr_accepted = 1'b0;
        put(32'h200, 32'h0000BEEF, 4'h3);
        put(32'h200, 32'h00001200, 4'h2);
        load_req_addr = 32'h200;
        #1;
        chk("fwd_data", wb_load_data, 32'h000012EF);
        chk("fwd_mask", wb_data_mask, 4'h3);
        load_req_addr = 32'h204;
        #1;
        chk("fwd_other_half_mask", wb_data_mask, 4'h0);
        chk("fwd_other_half_data", wb_load_data, 32'h0);
        drain_until_empty("fwd");
        tick();

        // Wrap and drain_all
        base = wlog.size();
        for (int k = 0; k < 6; k++) begin
            dc_wr_accepted = k[0];
            put(32'h400 + 32'(8 * k), 32'hC0DE0000 + 32'(k), 4'hF);
        end
        drain_until_empty("wrap");
        chk("wrap_writes", wlog.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (wlog.size() >= base + k + 1) begin
                chk("wrap_addr", {wlog[base+k].blk, 3'b000}, 32'h400 + 32'(8 * k));
                chk("wrap_data", wlog[base+k].data, {32'h0, 32'hC0DE0000 + 32'(k)});
            end
        end
        tick();

        // Reset mid-PRESENT
        dc_wr_accepted = 1'b0;
        put(32'h500, 32'h55555555, 4'hF);
        put(32'h508, 32'h66666666, 4'hF);
        n = 0;
        while (!dc_wr_valid && n < 10) begin
            tick();
            n++;
        end
        chk("pre_reset_valid", dc_wr_valid, 1'b1);
        load_req_addr = 32'h500;
        #1;
        chk("pre_reset_fwd_mask", wb_data_mask, 4'hF);
        reset = 1'b1;
        tick();
        chk("post_reset_valid", dc_wr_valid, 1'b0);
        chk("post_reset_empty", wb_empty, 1'b1);
        chk("post_reset_fwd_mask", wb_data_mask, 4'h0);
        chk("post_reset_fwd_data", wb_load_data, 32'h0);
        reset = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
